round_demux: RTL

//  Output-side counterpart of the round-input mux in the byte-serial AES-128 datapath.

---
 rtl/round_demux_if.sv | 30 +++
 rtl/round_demux.sv | 129 ++++++++++++
 2 files changed

// File: rtl/round_demux_if.sv
// Byte-stream bundle between the round pipeline and the round output demux.
interface round_demux_if;
  logic       start;
  logic [7:0] din;
  logic       enable_din;
  logic [7:0] dout_round1;
  logic       enable_round1;
  logic [7:0] dout_final;
  logic       enable_final;
  logic       last_round;
  logic [3:0] round_cnt;
  logic [3:0] byte_cnt;
  logic       block_done;
  logic       abort;
  logic       stray;

  // Upstream side: feeds bytes, observes steering and position.
  modport master (
    output start, din, enable_din,
    input  dout_round1, enable_round1, dout_final, enable_final, last_round,
    input  round_cnt, byte_cnt, block_done, abort, stray
  );

  // Demux side.
  modport slave (
    input  start, din, enable_din,
    output dout_round1, enable_round1, dout_final, enable_final, last_round,
    output round_cnt, byte_cnt, block_done, abort, stray
  );
endinterface

// File: rtl/round_demux.sv
// Steers bytes leaving the AES round pipeline: intermediate rounds go back to the
// round-input mux, the final round goes to the ciphertext output.
module round_demux #(
  parameter int unsigned BYTES_PER_BLOCK = 16,
  parameter int unsigned NUM_ROUNDS      = 10
) (
  input logic          clk,
  input logic          rst,
  round_demux_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoop, StLast} state_e;

  localparam logic [3:0] LastByte   = 4'(BYTES_PER_BLOCK - 1);
  localparam logic [3:0] FinalRound = 4'(NUM_ROUNDS);

  state_e     state_q, state_d;
  logic [3:0] byte_cnt_q, byte_cnt_d;
  logic [3:0] round_cnt_q, round_cnt_d;
  logic [7:0] dout_round1_q, dout_round1_d;
  logic [7:0] dout_final_q, dout_final_d;
  logic       enable_round1_q, enable_round1_d;
  logic       enable_final_q, enable_final_d;
  logic       last_round_q, last_round_d;
  logic       block_done_q, block_done_d;
  logic       abort_q, abort_d;
  logic       stray_q, stray_d;

  // Next-state: start has priority over any byte arriving in the same cycle.
  always_comb begin
    state_d         = state_q;
    byte_cnt_d      = byte_cnt_q;
    round_cnt_d     = round_cnt_q;
    dout_round1_d   = dout_round1_q;
    dout_final_d    = dout_final_q;
    enable_round1_d = 1'b0;
    enable_final_d  = 1'b0;
    block_done_d    = 1'b0;
    abort_d         = 1'b0;
    stray_d         = 1'b0;

    if (bus.start) begin
      abort_d     = (state_q != StIdle);
      state_d     = StLoop;
      byte_cnt_d  = 4'd0;
      round_cnt_d = 4'd1;
    end else if (bus.enable_din) begin
      case (state_q)
        StIdle: begin
          stray_d = 1'b1;
        end
        StLoop: begin
          dout_round1_d   = bus.din;
          enable_round1_d = 1'b1;
          if (byte_cnt_q == LastByte) begin
            byte_cnt_d  = 4'd0;
            round_cnt_d = round_cnt_q + 4'd1;
            if (round_cnt_q + 4'd1 == FinalRound) begin
              state_d = StLast;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
        StLast: begin
          dout_final_d   = bus.din;
          enable_final_d = 1'b1;
          if (byte_cnt_q == LastByte) begin
            block_done_d = 1'b1;
            state_d      = StIdle;
            byte_cnt_d   = 4'd0;
            round_cnt_d  = 4'd1;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
        default: begin
          state_d     = StIdle;
          byte_cnt_d  = 4'd0;
          round_cnt_d = 4'd1;
        end
      endcase
    end

    // Registered alongside the state so it tracks the round actually arriving.
    last_round_d = (state_d == StLast);
  end

  // State and output registers; reset discards any partial block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      byte_cnt_q      <= 4'd0;
      round_cnt_q     <= 4'd1;
      dout_round1_q   <= 8'd0;
      dout_final_q    <= 8'd0;
      enable_round1_q <= 1'b0;
      enable_final_q  <= 1'b0;
      last_round_q    <= 1'b0;
      block_done_q    <= 1'b0;
      abort_q         <= 1'b0;
      stray_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      byte_cnt_q      <= byte_cnt_d;
      round_cnt_q     <= round_cnt_d;
      dout_round1_q   <= dout_round1_d;
      dout_final_q    <= dout_final_d;
      enable_round1_q <= enable_round1_d;
      enable_final_q  <= enable_final_d;
      last_round_q    <= last_round_d;
      block_done_q    <= block_done_d;
      abort_q         <= abort_d;
      stray_q         <= stray_d;
    end
  end

  assign bus.dout_round1   = dout_round1_q;
  assign bus.enable_round1 = enable_round1_q;
  assign bus.dout_final    = dout_final_q;
  assign bus.enable_final  = enable_final_q;
  assign bus.last_round    = last_round_q;
  assign bus.round_cnt     = round_cnt_q;
  assign bus.byte_cnt      = byte_cnt_q;
  assign bus.block_done    = block_done_q;
  assign bus.abort         = abort_q;
  assign bus.stray         = stray_q;

endmodule
